// File: rtl/sample_framer.sv
// Sample FIFO plus frame FSM feeding the averaging accumulator with sof/eof-marked frames.
// Define SAMPLE_FRAMER_DROP_EN for a non-stalling input that drops samples when the FIFO is full.
module sample_framer #(
    parameter int unsigned C_DATA_WIDTH = 54,
    parameter int unsigned FIFO_AW      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [9:0]              cfg_frame_len,
    input  logic [C_DATA_WIDTH-1:0] s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic [C_DATA_WIDTH-1:0] DATA_out,
    output logic                    DATA_sof,
    output logic                    DATA_eof,
    output logic                    DATA_valid,
    input  logic                    DATA_ready,
    output logic [15:0]             frame_cnt,
    output logic [15:0]             ovf_cnt
);

    localparam int unsigned Depth = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0]   DepthCnt = (FIFO_AW + 1)'(Depth);
    localparam logic [FIFO_AW:0]   CntOne   = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PtrOne   = FIFO_AW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StEof,
        StGap
    } state_e;

    // FIFO storage and control
    logic [C_DATA_WIDTH-1:0] mem_q [Depth];
    logic [FIFO_AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]        count_q, count_d;
    logic                    full_q, empty;
    logic                    s_ready_q, s_ready_d;
    logic                    fifo_wr, fifo_rd;
    logic [C_DATA_WIDTH-1:0] fifo_rd_data;

    // Frame FSM and output register
    state_e                  state_q;
    logic [9:0]              len_q, pos_q;
    logic                    gap_first_q;
    logic [C_DATA_WIDTH-1:0] out_data_q;
    logic                    out_valid_q, sof_q, eof_q;
    logic [15:0]             frame_cnt_q;

    logic       can_take, start, cont, load_sof, load_eof;
    logic [9:0] cur_len, cur_pos;

    assign empty        = (count_q == '0);
    assign fifo_rd_data = mem_q[rd_ptr_q];

`ifdef SAMPLE_FRAMER_DROP_EN
    logic [15:0] ovf_q;

    // Input never stalls; anything offered against a full FIFO is lost and counted.
    assign fifo_wr   = s_valid && s_ready_q && !full_q;
    assign s_ready_d = 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= '0;
        end else if (s_valid && s_ready_q && full_q && (ovf_q != 16'hFFFF)) begin
            ovf_q <= ovf_q + 16'd1;
        end
    end

    assign ovf_cnt = ovf_q;
`else
    assign fifo_wr   = s_valid && s_ready_q;
    assign s_ready_d = (count_d != DepthCnt);
    assign ovf_cnt   = '0;
`endif

    always_comb begin
        count_d = count_q;
        if (fifo_wr && !fifo_rd) begin
            count_d = count_q + CntOne;
        end else if (!fifo_wr && fifo_rd) begin
            count_d = count_q - CntOne;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            s_ready_q <= 1'b0;
        end else begin
            if (fifo_wr) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (fifo_rd) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
            count_q   <= count_d;
            full_q    <= (count_d == DepthCnt);
            s_ready_q <= s_ready_d;
        end
    end

    // Frame start loads the first sample in the same cycle the length is latched,
    // so the idle-to-output latency stays at two cycles.
    always_comb begin
        can_take = !out_valid_q || DATA_ready;
        start    = (state_q == StIdle) && (cfg_frame_len != '0) && !empty;
        cont     = (state_q == StStream) && !empty && can_take;
        fifo_rd  = start || cont;
        cur_len  = start ? cfg_frame_len : len_q;
        cur_pos  = start ? '0 : pos_q;
        load_sof = (cur_pos == '0);
        load_eof = (cur_pos == (cur_len - 10'd1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            len_q       <= '0;
            pos_q       <= '0;
            gap_first_q <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        len_q <= cfg_frame_len;
                    end
                end
                StStream: begin
                    // FIFO ran dry mid-frame: retire the accepted sample, keep pos.
                    if (!fifo_rd && out_valid_q && DATA_ready) begin
                        out_valid_q <= 1'b0;
                        sof_q       <= 1'b0;
                        eof_q       <= 1'b0;
                    end
                end
                StEof: begin
                    if (DATA_ready) begin
                        out_valid_q <= 1'b0;
                        sof_q       <= 1'b0;
                        eof_q       <= 1'b0;
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                        gap_first_q <= 1'b1;
                        state_q     <= StGap;
                    end
                end
                StGap: begin
                    gap_first_q <= 1'b0;
                    if (!gap_first_q && DATA_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (fifo_rd) begin
                out_data_q  <= fifo_rd_data;
                out_valid_q <= 1'b1;
                sof_q       <= load_sof;
                eof_q       <= load_eof;
                pos_q       <= cur_pos + 10'd1;
                state_q     <= load_eof ? StEof : StStream;
            end
        end
    end

    assign s_ready    = s_ready_q;
    assign DATA_out   = out_data_q;
    assign DATA_sof   = sof_q;
    assign DATA_eof   = eof_q;
    assign DATA_valid = out_valid_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_sample_framer.sv
// Directed bench for sample_framer: framing, stalls, length handling, FIFO full, reset, hold-off.
module tb_sample_framer;

    localparam int W = 54;

`ifdef SAMPLE_FRAMER_DROP_EN
    localparam int ExpDeliv    = 17;
    localparam int ExpFirstLow = -1;
    localparam int ExpOvf      = 3;
`else
    localparam int ExpDeliv    = 20;
    localparam int ExpFirstLow = 17;
    localparam int ExpOvf      = 0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [9:0]   cfg_frame_len = '0;
    logic [W-1:0] s_data = '0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [W-1:0] DATA_out;
    logic         DATA_sof, DATA_eof, DATA_valid;
    logic         DATA_ready = 1'b1;
    logic [15:0]  frame_cnt, ovf_cnt;

    int tests = 0;
    int fails = 0;
    int viol  = 0;
    bit acc_mode = 1'b0;
    int acc_hold = 0;

    logic [W-1:0] q_data [$];
    logic         q_sof  [$];
    logic         q_eof  [$];

    sample_framer #(
        .C_DATA_WIDTH (W),
        .FIFO_AW      (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_frame_len (cfg_frame_len),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .DATA_out      (DATA_out),
        .DATA_sof      (DATA_sof),
        .DATA_eof      (DATA_eof),
        .DATA_valid    (DATA_valid),
        .DATA_ready    (DATA_ready),
        .frame_cnt     (frame_cnt),
        .ovf_cnt       (ovf_cnt)
    );

    always #5 clk = ~clk;

    // Transfer monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (!DATA_valid && (DATA_sof || DATA_eof)) viol++;
            if (DATA_valid && DATA_ready) begin
                q_data.push_back(DATA_out);
                q_sof.push_back(DATA_sof);
                q_eof.push_back(DATA_eof);
                if (DATA_eof && acc_mode) acc_hold = 5;
            end
        end
    end

    // Accumulator model: ready drops after eof and returns five cycles later
    always @(posedge clk) begin
        #1;
        if (acc_mode) begin
            DATA_ready = (acc_hold == 0);
            if (acc_hold > 0) acc_hold--;
        end
    end

    task automatic push(input logic [W-1:0] d);
        s_valid = 1'b1;
        s_data  = d;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_q(input int n, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (q_data.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        q_data.delete();
        q_sof.delete();
        q_eof.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++;
        if (s_ready !== 1'b0) begin
            fails++; $display("FAIL reset_s_ready_low: got %0b want 0", s_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (s_ready !== 1'b1) begin
            fails++; $display("FAIL reset_s_ready_high: got %0b want 1", s_ready);
        end
        tests++;
        if ({DATA_valid, DATA_sof, DATA_eof} !== 3'b000 || DATA_out !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got v%0b s%0b e%0b d%0h want all 0",
                     DATA_valid, DATA_sof, DATA_eof, DATA_out);
        end
        tests++;
        if (frame_cnt !== 16'd0 || ovf_cnt !== 16'd0) begin
            fails++; $display("FAIL reset_counters: got %0h/%0h want 0/0", frame_cnt, ovf_cnt);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_framing();
        logic         hv [8];
        logic [W-1:0] hd [8];
        logic         es [8] = '{1, 0, 0, 0, 1, 0, 0, 0};
        logic         ee [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
        bit ok;
        cfg_frame_len = 10'd4;
        acc_hold = 0;
        acc_mode = 1'b1;
        DATA_ready = 1'b1;
        clear_q();
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1;
            s_data  = W'(i + 1);
            @(negedge clk);
            hv[i] = DATA_valid;
            hd[i] = DATA_out;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        tests++;
        if (hv[0] !== 1'b0 || hv[1] !== 1'b0 || hv[2] !== 1'b1) begin
            fails++; $display("FAIL latency: got valid %0b%0b%0b want 001", hv[0], hv[1], hv[2]);
        end
        tests++;
        if (hd[2] !== W'(1)) begin
            fails++; $display("FAIL latency_data: got %0h want 1", hd[2]);
        end
        wait_q(8, 200, ok);
        tests++;
        if (!ok || q_data.size() != 8) begin
            fails++; $display("FAIL framing_count: got %0d want 8", q_data.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                tests++;
                if (q_data[i] !== W'(i + 1) || q_sof[i] !== es[i] || q_eof[i] !== ee[i]) begin
                    fails++;
                    $display("FAIL framing[%0d]: got d%0h s%0b e%0b want d%0h s%0b e%0b",
                             i, q_data[i], q_sof[i], q_eof[i], i + 1, es[i], ee[i]);
                end
            end
        end
        tests++;
        if (frame_cnt !== 16'd2) begin
            fails++; $display("FAIL framing_frame_cnt: got %0d want 2", frame_cnt);
        end
        acc_mode = 1'b0;
        DATA_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_stall();
        bit ok;
        cfg_frame_len = 10'd4;
        DATA_ready = 1'b1;
        clear_q();
        for (int i = 0; i < 4; i++) push(W'(8'h21 + i));
        DATA_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests++;
            if (!DATA_valid || DATA_out !== W'(8'h23) || DATA_sof || DATA_eof) begin
                fails++;
                $display("FAIL stall_hold[%0d]: got v%0b d%0h s%0b e%0b want v1 d23 s0 e0",
                         c, DATA_valid, DATA_out, DATA_sof, DATA_eof);
            end
        end
        @(posedge clk);
        #1;
        DATA_ready = 1'b1;
        wait_q(4, 100, ok);
        tests++;
        if (!ok || q_data.size() != 4) begin
            fails++; $display("FAIL stall_count: got %0d want 4", q_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (q_data[i] !== W'(8'h21 + i) || q_sof[i] !== (i == 0) || q_eof[i] !== (i == 3)) begin
                    fails++;
                    $display("FAIL stall_seq[%0d]: got d%0h s%0b e%0b want d%0h", i, q_data[i],
                             q_sof[i], q_eof[i], 8'h21 + i);
                end
            end
        end
    endtask

    task automatic test_len_change();
        bit ok;
        logic es [7] = '{1, 0, 0, 0, 1, 0, 0};
        logic ee [7] = '{0, 0, 0, 1, 0, 0, 1};
        cfg_frame_len = 10'd1;
        DATA_ready = 1'b1;
        clear_q();
        for (int i = 0; i < 3; i++) push(W'(8'h31 + i));
        wait_q(3, 100, ok);
        tests++;
        if (!ok || q_data.size() != 3) begin
            fails++; $display("FAIL len1_count: got %0d want 3", q_data.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests++;
                if (q_data[i] !== W'(8'h31 + i) || q_sof[i] !== 1'b1 || q_eof[i] !== 1'b1) begin
                    fails++;
                    $display("FAIL len1[%0d]: got d%0h s%0b e%0b want d%0h s1 e1", i, q_data[i],
                             q_sof[i], q_eof[i], 8'h31 + i);
                end
            end
        end
        cfg_frame_len = 10'd4;
        clear_q();
        for (int i = 0; i < 7; i++) begin
            if (i == 3) cfg_frame_len = 10'd3;
            push(W'(8'h41 + i));
        end
        wait_q(7, 100, ok);
        tests++;
        if (!ok || q_data.size() != 7) begin
            fails++; $display("FAIL lenchg_count: got %0d want 7", q_data.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                tests++;
                if (q_data[i] !== W'(8'h41 + i) || q_sof[i] !== es[i] || q_eof[i] !== ee[i]) begin
                    fails++;
                    $display("FAIL lenchg[%0d]: got d%0h s%0b e%0b want d%0h s%0b e%0b", i,
                             q_data[i], q_sof[i], q_eof[i], 8'h41 + i, es[i], ee[i]);
                end
            end
        end
    endtask

    task automatic test_fifo_full();
        bit ok;
        int idx = 0;
        int first_low = -1;
        cfg_frame_len = 10'd1;
        DATA_ready = 1'b0;
        clear_q();
        for (int cyc = 0; cyc < 200 && idx < 20; cyc++) begin
            if (cyc == 30) DATA_ready = 1'b1;
            s_valid = 1'b1;
            s_data  = W'(8'h51 + idx);
            @(negedge clk);
            if (s_ready) idx++;
            else if (first_low < 0) first_low = idx;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        DATA_ready = 1'b1;
        tests++;
        if (first_low != ExpFirstLow) begin
            fails++; $display("FAIL full_s_ready: got low after %0d want %0d", first_low, ExpFirstLow);
        end
        wait_q(ExpDeliv, 400, ok);
        tests++;
        if (!ok || q_data.size() != ExpDeliv) begin
            fails++; $display("FAIL full_delivered: got %0d want %0d", q_data.size(), ExpDeliv);
        end else begin
            for (int i = 0; i < ExpDeliv; i++) begin
                tests++;
                if (q_data[i] !== W'(8'h51 + i)) begin
                    fails++; $display("FAIL full_seq[%0d]: got %0h want %0h", i, q_data[i], 8'h51 + i);
                end
            end
        end
        tests++;
        if (ovf_cnt !== 16'(ExpOvf)) begin
            fails++; $display("FAIL full_ovf_cnt: got %0d want %0d", ovf_cnt, ExpOvf);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        cfg_frame_len = 10'd4;
        DATA_ready = 1'b1;
        push(W'(8'h71));
        push(W'(8'h72));
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if ({DATA_valid, DATA_sof, DATA_eof, s_ready} !== 4'b0000 || DATA_out !== '0) begin
            fails++;
            $display("FAIL rstmid_outputs: got v%0b s%0b e%0b r%0b d%0h want all 0",
                     DATA_valid, DATA_sof, DATA_eof, s_ready, DATA_out);
        end
        tests++;
        if (frame_cnt !== 16'd0) begin
            fails++; $display("FAIL rstmid_frame_cnt: got %0d want 0", frame_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        clear_q();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) push(W'(8'h81 + i));
        wait_q(4, 100, ok);
        tests++;
        if (!ok || q_data.size() != 4) begin
            fails++; $display("FAIL rstmid_count: got %0d want 4", q_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (q_data[i] !== W'(8'h81 + i) || q_sof[i] !== (i == 0) || q_eof[i] !== (i == 3)) begin
                    fails++;
                    $display("FAIL rstmid_seq[%0d]: got d%0h s%0b e%0b want d%0h", i, q_data[i],
                             q_sof[i], q_eof[i], 8'h81 + i);
                end
            end
        end
        tests++;
        if (frame_cnt !== 16'd1) begin
            fails++; $display("FAIL rstmid_frames: got %0d want 1", frame_cnt);
        end
    endtask

    task automatic test_hold_off();
        bit ok;
        int seen = 0;
        logic es [4] = '{1, 0, 1, 0};
        logic ee [4] = '{0, 1, 0, 1};
        cfg_frame_len = 10'd0;
        DATA_ready = 1'b1;
        clear_q();
        for (int i = 0; i < 3; i++) push(W'(8'h91 + i));
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (DATA_valid) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++; $display("FAIL holdoff_valid: got %0d valid cycles want 0", seen);
        end
        @(posedge clk);
        #1;
        cfg_frame_len = 10'd2;
        push(W'(8'h94));
        wait_q(4, 100, ok);
        tests++;
        if (!ok || q_data.size() != 4) begin
            fails++; $display("FAIL holdoff_count: got %0d want 4", q_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (q_data[i] !== W'(8'h91 + i) || q_sof[i] !== es[i] || q_eof[i] !== ee[i]) begin
                    fails++;
                    $display("FAIL holdoff_seq[%0d]: got d%0h s%0b e%0b want d%0h s%0b e%0b", i,
                             q_data[i], q_sof[i], q_eof[i], 8'h91 + i, es[i], ee[i]);
                end
            end
        end
        tests++;
        if (frame_cnt !== 16'd3) begin
            fails++; $display("FAIL holdoff_frames: got %0d want 3", frame_cnt);
        end
    endtask

    task automatic test_flag_gating();
        tests++;
        if (viol != 0) begin
            fails++; $display("FAIL flag_gating: got %0d cycles with sof/eof while !valid want 0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_framing();
        test_stall();
        test_len_change();
        test_fifo_full();
        test_reset_mid_frame();
        test_hold_off();
        test_flag_gating();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
